immgen_pipe: RTL



---
 rtl/riscv_pkg.sv | 25 ++
 rtl/imm_decode.sv | 55 +++++
 rtl/immgen_pipe.sv | 74 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV64I opcode constants and immediate-format codes shared by the decode stages
package riscv_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode decode producing the extended immediate, format and illegal flag
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_ix,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal
);
    logic [6:0]      w_op;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;

    assign w_op       = i_ix[6:0];
    assign w_is_shift = (w_op == OP_IMM || w_op == OP_IMM32) && i_ix[13:12] == 2'b01;
    assign w_imm_i    = XLEN'($signed(i_ix[31:20]));
    assign w_imm_s    = XLEN'($signed({i_ix[31:25], i_ix[11:7]}));
    assign w_imm_b    = XLEN'($signed({i_ix[31], i_ix[7], i_ix[30:25], i_ix[11:8], 1'b0}));
    assign w_imm_u    = XLEN'($signed({i_ix[31:12], 12'b0}));
    assign w_imm_j    = XLEN'($signed({i_ix[31], i_ix[19:12], i_ix[20], i_ix[30:21], 1'b0}));
    // shamt is 6 bits only for 64-bit OP-IMM shifts; the W forms always use 5
    assign w_shamt    = (XLEN == 64 && w_op == OP_IMM) ? XLEN'(i_ix[25:20]) : XLEN'(i_ix[24:20]);

    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_ILL;
        o_illegal = 1'b0;
        case (w_op)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
                o_fmt = FMT_I;
                o_imm = w_is_shift ? w_shamt : w_imm_i;
            end
            OP_STORE: begin
                o_fmt = FMT_S;
                o_imm = w_imm_s;
            end
            OP_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = w_imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = w_imm_u;
            end
            OP_JAL: begin
                o_fmt = FMT_J;
                o_imm = w_imm_j;
            end
            OP_REG, OP_REG32: o_fmt = FMT_R;
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate generator with valid/ready handshake, optional skid entry and flush
module immgen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TAG_W   = 64,
    parameter int SKID_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ix,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_ix
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
        logic [31:0]      ix;
    } ent_t;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill, w_acc, w_ret, w_free, w_to_skid, w_ld_main;
    ent_t            w_in, r_main, r_skid;
    logic            r_v, r_sv;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_ix      (in_ix),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_ill)
    );

    assign w_in      = '{imm: w_imm, fmt: w_fmt, ill: w_ill, tag: in_tag, ix: in_ix};
    assign in_ready  = (SKID_EN != 0) ? !r_sv : (!r_v || out_ready);
    assign w_acc     = in_valid && in_ready;
    assign w_ret     = r_v && out_ready;
    assign w_free    = !r_v || w_ret;
    // an arrival that cannot go straight to the output register parks in the skid entry
    assign w_to_skid = (SKID_EN != 0) && w_acc && !w_free && !flush;
    assign w_ld_main = w_free && (r_sv || w_acc) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= 1'b0;
            r_sv   <= 1'b0;
            r_main <= '0;
            r_skid <= '0;
        end else begin
            r_v  <= !flush && (w_free ? (r_sv || w_acc) : 1'b1);
            r_sv <= !flush && (w_to_skid || (r_sv && !w_ret));
            if (w_ld_main) r_main <= r_sv ? r_skid : w_in;
            if (w_to_skid) r_skid <= w_in;
        end
    end

    assign out_valid   = r_v;
    assign out_imm     = r_main.imm;
    assign out_fmt     = r_main.fmt;
    assign out_illegal = r_main.ill;
    assign out_tag     = r_main.tag;
    assign out_ix      = r_main.ix;
endmodule
